// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment patterns used by the display
// drivers, 4-bit character codes and the pattern-to-code decoder.
package seven_seg_pkg;

    // Segment patterns, bit 7 = a ... bit 0 = h (dot), dot clear.
    typedef enum logic [7:0] {
        SEG_SPACE = 8'h00,
        SEG_A     = 8'hEE,
        SEG_E     = 8'h9E,
        SEG_F     = 8'h8E,
        SEG_G     = 8'hBC,
        SEG_K     = 8'hAE,
        SEG_O     = 8'hFC,
        SEG_P     = 8'hCE,
        SEG_R     = 8'hCC
    } seg_pattern_e;

    localparam logic [3:0] CODE_SPACE   = 4'h0;
    localparam logic [3:0] CODE_A       = 4'h1;
    localparam logic [3:0] CODE_E       = 4'h2;
    localparam logic [3:0] CODE_F       = 4'h3;
    localparam logic [3:0] CODE_G       = 4'h4;
    localparam logic [3:0] CODE_K       = 4'h5;
    localparam logic [3:0] CODE_O       = 4'h6;
    localparam logic [3:0] CODE_P       = 4'h7;
    localparam logic [3:0] CODE_R       = 4'h8;
    localparam logic [3:0] CODE_UNKNOWN = 4'hF;

    // The dot segment carries no character information, so it is masked.
    function automatic logic [3:0] decode_pattern(input logic [7:0] seg);
        logic [7:0] m;
        logic [3:0] c;
        m = {seg[7:1], 1'b0};
        case (m)
            SEG_SPACE: c = CODE_SPACE;
            SEG_A:     c = CODE_A;
            SEG_E:     c = CODE_E;
            SEG_F:     c = CODE_F;
            SEG_G:     c = CODE_G;
            SEG_K:     c = CODE_K;
            SEG_O:     c = CODE_O;
            SEG_P:     c = CODE_P;
            SEG_R:     c = CODE_R;
            default:   c = CODE_UNKNOWN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seven_seg_word_decoder_dwell_filter.sv
// Synchronizes the segment/digit pins and emits one capture per position
// once a one-hot strobe and its pattern have been steady long enough.
module seven_seg_dwell_filter
    import seven_seg_pkg::*;
#(
    parameter int w_digit      = 8,
    parameter int dwell_cycles = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         abcdefgh,
    input  logic [w_digit-1:0] digit,
    output logic               capture,
    output logic [w_digit-1:0] pos,
    output logic [7:0]         pattern
);

    localparam int SW = 8 + w_digit;
    localparam int CW = $clog2(dwell_cycles) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(dwell_cycles - 1);
    localparam logic [CW-1:0] CNT_FIRE = CW'(dwell_cycles - 2);

    logic [SW-1:0]      meta;
    logic [SW-1:0]      sync;
    logic [SW-1:0]      prev;
    logic [CW-1:0]      cnt;
    logic [w_digit-1:0] sdig;
    logic               one_hot;
    logic               same;
    logic               fire;

    assign sdig    = sync[w_digit-1:0];
    assign one_hot = (sdig != '0) && ((sdig & (sdig - 1'b1)) == '0);
    assign same    = (sync == prev);
    assign fire    = same && one_hot && (cnt == CNT_FIRE);

    // Two-flop synchronizer plus one-cycle history for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= {abcdefgh, digit};
            sync <= meta;
            prev <= sync;
        end
    end

    // Dwell counter saturates at its last value so a held strobe fires once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (same && one_hot) begin
            if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Registered capture pulse with the position and pattern that caused it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capture <= 1'b0;
            pos     <= '0;
            pattern <= '0;
        end else begin
            capture <= fire;
            if (fire) begin
                pos     <= sdig;
                pattern <= sync[SW-1 -: 8];
            end
        end
    end

endmodule

// File: rtl/seven_seg_word_decoder.sv
// Rebuilds the displayed word from a sampled multiplexed seven-segment bus
// and reports frame completion, stability, unknown patterns and link loss.
module seven_seg_word_decoder
    import seven_seg_pkg::*;
#(
    parameter int w_digit        = 8,
    parameter int dwell_cycles   = 16,
    parameter int stable_frames  = 2,
    parameter int timeout_cycles = 2 ** 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           abcdefgh,
    input  logic [w_digit-1:0]   digit,
    output logic [4*w_digit-1:0] word,
    output logic                 frame_valid,
    output logic                 word_stable,
    output logic                 bad_pattern,
    output logic                 link_lost
);

    localparam int MW = $clog2(stable_frames) + 1;
    localparam int TW = $clog2(timeout_cycles) + 1;
    localparam logic [MW-1:0] MATCH_MAX = MW'(stable_frames);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(timeout_cycles);
    localparam logic [TW-1:0] IDLE_LAST = TW'(timeout_cycles - 1);

    logic                 capture;
    logic [w_digit-1:0]   pos;
    logic [7:0]           pattern;
    logic [3:0]           code;

    logic [4*w_digit-1:0] stage;
    logic [4*w_digit-1:0] stage_next;
    logic [w_digit-1:0]   seen;
    logic [w_digit-1:0]   seen_next;
    logic [MW-1:0]        match;
    logic [MW-1:0]        match_next;
    logic [TW-1:0]        idle;
    logic                 frame_done;
    logic                 bad_next;

    seven_seg_dwell_filter #(
        .w_digit      (w_digit),
        .dwell_cycles (dwell_cycles)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .abcdefgh (abcdefgh),
        .digit    (digit),
        .capture  (capture),
        .pos      (pos),
        .pattern  (pattern)
    );

    assign code = decode_pattern(pattern);

    // Staging update, frame completion and new-frame status, ahead of the clock.
    always_comb begin
        stage_next = stage;
        seen_next  = seen | pos;
        bad_next   = 1'b0;
        for (int i = 0; i < w_digit; i++) begin
            if (pos[i]) stage_next[4*i +: 4] = code;
        end
        for (int i = 0; i < w_digit; i++) begin
            if (stage_next[4*i +: 4] == CODE_UNKNOWN) bad_next = 1'b1;
        end
        frame_done = capture && (seen_next == '1);
        if (stage_next != word)    match_next = MW'(1);
        else if (match == MATCH_MAX) match_next = match;
        else                       match_next = match + MW'(1);
    end

    // Frame assembly, stability tracking and link timeout; capture beats timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word        <= '0;
            frame_valid <= 1'b0;
            word_stable <= 1'b0;
            bad_pattern <= 1'b0;
            link_lost   <= 1'b0;
            stage       <= '0;
            seen        <= '0;
            match       <= '0;
            idle        <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (capture) begin
                idle      <= '0;
                link_lost <= 1'b0;
                stage     <= stage_next;
                if (frame_done) begin
                    word        <= stage_next;
                    frame_valid <= 1'b1;
                    seen        <= '0;
                    bad_pattern <= bad_next;
                    match       <= match_next;
                    word_stable <= (match_next == MATCH_MAX);
                end else begin
                    seen <= seen_next;
                end
            end else if (idle != IDLE_MAX) begin
                idle <= idle + TW'(1);
                if (idle == IDLE_LAST) begin
                    link_lost   <= 1'b1;
                    seen        <= '0;
                    match       <= '0;
                    word_stable <= 1'b0;
                end
            end
        end
    end

endmodule
